// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit and its neighbours
// (forward_unit reuses the register-index constants).
package hazard_detection_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hdu_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A load in EX feeds a source of the ID instruction; register 0 is never a real dependency.
    function automatic logic load_use(
        input logic                 mem_read,
        input logic [REG_IDX_W-1:0] ex_rt,
        input logic [REG_IDX_W-1:0] id_rs,
        input logic [REG_IDX_W-1:0] id_rt,
        input logic                 uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-control bundle between ID-stage decode and the hazard detection unit.
// HAZARD_STALL_COUNTER_EN adds the stall/flush statistics counters.
interface hazard_detection_unit_if;
    import hazard_detection_unit_pkg::*;

    logic                 ID_EX_MemRead;
    logic [REG_IDX_W-1:0] ID_EX_RegisterRt;
    logic [REG_IDX_W-1:0] IF_ID_RegisterRs;
    logic [REG_IDX_W-1:0] IF_ID_RegisterRt;
    logic                 IF_ID_UsesRt;
    logic                 Branch_Taken;
    logic                 Jump;
    logic                 PC_Write;
    logic                 IF_ID_Write;
    logic                 IF_ID_Flush;
    logic                 ID_EX_Bubble;
    logic                 Stall_Active;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0]          Stall_Count;
    logic [31:0]          Flush_Count;
`endif

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, Branch_Taken, Jump,
`ifdef HAZARD_STALL_COUNTER_EN
        input  Stall_Count, Flush_Count,
`endif
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Active
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, Branch_Taken, Jump,
`ifdef HAZARD_STALL_COUNTER_EN
        output Stall_Count, Flush_Count,
`endif
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_Active
    );

endinterface

// File: rtl/hazard_detection_unit_cycle_counter.sv
// Loadable down-counter shared by the STALL and FLUSH holds; term_o flags the last held cycle.
module hazard_cycle_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down to zero and rest there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == W'(1));

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and branch/jump flush control for the ID stage.
// Optional statistics counters are enabled with HAZARD_STALL_COUNTER_EN.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_detection_unit_if.slave hdu
);

    localparam int CNT_W = $clog2(max2(LOAD_STALL_CYCLES, FLUSH_CYCLES)) + 1;

    hdu_state_e       state_q;
    hdu_state_e       state_d;
    logic             lu_s;
    logic             br_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_term_s;
    logic             pc_write_s;
    logic             ifid_write_s;
    logic             flush_s;
    logic             bubble_s;
    logic             stall_s;

    assign lu_s = load_use(hdu.ID_EX_MemRead, hdu.ID_EX_RegisterRt, hdu.IF_ID_RegisterRs,
                           hdu.IF_ID_RegisterRt, hdu.IF_ID_UsesRt);
    assign br_s = hdu.Branch_Taken || hdu.Jump;

    hazard_cycle_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .term_o     (cnt_term_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter-load decode.
    always_comb begin
        state_d    = state_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        case (state_q)
            RUN: begin
                if (lu_s && (LOAD_STALL_CYCLES > 1)) begin
                    state_d    = STALL;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(LOAD_STALL_CYCLES - 1);
                end else if (!lu_s && br_s && (FLUSH_CYCLES > 1)) begin
                    state_d    = FLUSH;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = RUN;
                end
            end
            STALL: begin
                if (cnt_term_s) begin
                    state_d = RUN;
                end else begin
                    state_d = STALL;
                end
            end
            FLUSH: begin
                // A fresh redirect restarts the flush window instead of ending it.
                if (br_s && (FLUSH_CYCLES > 1)) begin
                    state_d    = FLUSH;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(FLUSH_CYCLES - 1);
                end else if (cnt_term_s) begin
                    state_d = RUN;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pipeline-control outputs, combinational so a hazard acts in the cycle it is seen.
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        flush_s      = 1'b0;
        bubble_s     = 1'b0;
        stall_s      = 1'b0;
        if (reset) begin
            pc_write_s = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_s) begin
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                        bubble_s     = 1'b1;
                        stall_s      = 1'b1;
                    end else if (br_s) begin
                        flush_s = 1'b1;
                    end else begin
                        flush_s = 1'b0;
                    end
                end
                STALL: begin
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                    bubble_s     = 1'b1;
                    stall_s      = 1'b1;
                end
                FLUSH: begin
                    flush_s = 1'b1;
                end
                default: begin
                    flush_s = 1'b0;
                end
            endcase
        end
    end

    assign hdu.PC_Write     = pc_write_s;
    assign hdu.IF_ID_Write  = ifid_write_s;
    assign hdu.IF_ID_Flush  = flush_s;
    assign hdu.ID_EX_Bubble = bubble_s;
    assign hdu.Stall_Active = stall_s;

`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_s && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hdu.Stall_Count = stall_cnt_q;
    assign hdu.Flush_Count = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Upstream neighbour of forward_unit; sits in ID and drives the PC, IF/ID and ID/EX register controls.
- Detects load-use hazards that forwarding cannot cover. Stalls PC and IF/ID and injects a bubble into ID/EX, holding for a configurable number of cycles.
- Also flushes IF/ID after a taken branch or jump, for a configurable number of cycles.

Parameters:
- LOAD_STALL_CYCLES, 1, total cycles of stall per load-use hazard (>=1; >1 models slow data memory).
- FLUSH_CYCLES, 1, total cycles IF_ID_Flush stays asserted per taken branch/jump (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RegisterRt  input  5  destination register of the load in EX.
- IF_ID_RegisterRs  input  5  Rs of the instruction in ID.
- IF_ID_RegisterRt  input  5  Rt of the instruction in ID.
- IF_ID_UsesRt  input  1  the ID instruction reads Rt as a source (suppresses false stalls on I-type).
- Branch_Taken  input  1  branch resolved taken this cycle.
- Jump  input  1  jump decoded this cycle.
- PC_Write  output  1  PC load enable (0 = hold).
- IF_ID_Write  output  1  IF/ID load enable (0 = hold).
- IF_ID_Flush  output  1  clear IF/ID to NOP.
- ID_EX_Bubble  output  1  zero ID/EX control signals.
- Stall_Active  output  1  high whenever PC/IF_ID are held.

Behaviour:
- Hazard term LU = ID_EX_MemRead && (ID_EX_RegisterRt != 0) && ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (IF_ID_UsesRt && ID_EX_RegisterRt == IF_ID_RegisterRt)).
- Redirect term BR = Branch_Taken || Jump.
- FSM states: RUN, STALL, FLUSH. A down-counter `cnt` is sized clog2(max(LOAD_STALL_CYCLES, FLUSH_CYCLES)) + 1.
- Outputs are combinational from state and inputs, so a hazard takes effect in the same cycle it is detected (zero latency).
- RUN, LU=1:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, Stall_Active=1.
  - BR is ignored; the branch in ID is re-evaluated after the stall.
  - If LOAD_STALL_CYCLES>1: next state STALL, cnt <= LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- RUN, LU=0, BR=1:
  - IF_ID_Flush=1; PC_Write=1, IF_ID_Write=1.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt <= FLUSH_CYCLES-1.
- RUN, neither: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, Stall_Active=0.
- STALL:
  - Same outputs as the RUN/LU case, regardless of inputs. LU and BR are ignored.
  - cnt decrements each cycle; when cnt==1 at a clock edge, next state is RUN.
  - Total stall length is exactly LOAD_STALL_CYCLES cycles.
- FLUSH:
  - IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0. LU is ignored because the ID contents are a bubble.
  - A new BR reloads cnt <= FLUSH_CYCLES-1.
  - When cnt==1 at a clock edge, next state is RUN.
- Reset (asynchronous, any state, including mid-stall/mid-flush):
  - state <= RUN, cnt <= 0.
  - While reset is high, outputs are forced to PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, Stall_Active=0.
- Register 0 never causes a stall. An unused Rt match with IF_ID_UsesRt=0 never causes a stall.
- An illegal state encoding recovers to RUN on the next edge.

Optional Feature:
- Macro: HAZARD_STALL_COUNTER_EN.
- Defined:
  - Adds output Stall_Count[31:0], which increments on every clock with Stall_Active=1.
  - Saturates at 32'hFFFF_FFFF and clears on reset.
  - Adds output Flush_Count[31:0] with the same rules for IF_ID_Flush=1.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - the state enum (RUN=2'd0, STALL=2'd1, FLUSH=2'd2);
  - REG_ZERO = 5'd0 and the 5-bit register-index width constant, both also used by forward_unit.
- One natural sub-module, hazard_cycle_counter: loadable down-counter with a terminal flag (cnt==1), instantiated once and shared by STALL and FLUSH.

Test Plan:
- Load-use on Rs with LOAD_STALL_CYCLES=1: ID_EX_MemRead=1, ID_EX_RegisterRt=5'd8, IF_ID_RegisterRs=5'd8.
  - Required: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle.
  - Then MemRead=0 and all outputs return to idle.
- Zero register and unused Rt: ID_EX_RegisterRt=0 with matching Rs gives no stall. ID_EX_RegisterRt=5'd9, IF_ID_RegisterRt=5'd9, IF_ID_UsesRt=0 gives no stall.
- LOAD_STALL_CYCLES=3: a single-cycle LU pulse must hold Stall_Active=1 for exactly 3 cycles. BR asserted during cycle 2 produces no IF_ID_Flush.
- FLUSH_CYCLES=2: a one-cycle Branch_Taken pulse must give IF_ID_Flush=1 for 2 cycles with PC_Write=1. Jump in cycle 2 extends the flush to cycle 3.
- Simultaneous LU and BR in RUN: stall outputs asserted and IF_ID_Flush=0.
- Reset asserted in cycle 2 of a 3-cycle stall: outputs return to idle immediately. After release, state is RUN; with HAZARD_STALL_COUNTER_EN, Stall_Count=0.
